// File: rtl/colision_pkg.sv
// Shared encodings for the HEROE multi-display collision checker:
// top-level presente codes, FSM states, bonus pattern and win/lose codes.
package colision_pkg;

  localparam logic [2:0] P_OFF  = 3'd0;
  localparam logic [2:0] P_WLCM = 3'd1;
  localparam logic [2:0] P_CH   = 3'd2;
  localparam logic [2:0] P_GAME = 3'd3;
  localparam logic [2:0] P_WL   = 3'd4;
  localparam logic [2:0] P_PA   = 3'd5;

  typedef enum logic [2:0] {
    INACTIVO,
    JUEGO,
    GOLPE,
    GANO,
    PERDIO
  } estado_t;

  localparam logic [6:0] BONO_PATRON = 7'h7F;

  localparam logic [1:0] WL_NADA   = 2'b00;
  localparam logic [1:0] WL_GANA   = 2'b10;
  localparam logic [1:0] WL_PIERDE = 2'b01;

endpackage

// File: rtl/detector_display.sv
// Per-display compare of obstacle segments against the hero segments.
// An all-ones obstacle is a bonus and never counts as a hit.
module detector_display
  import colision_pkg::*;
(
  input  logic [6:0] obs,
  input  logic [6:0] heroe,
  output logic       choque,
  output logic       es_bono
);

  assign es_bono = (obs == BONO_PATRON);
  assign choque  = (|(obs & heroe)) & ~es_bono;

endmodule

// File: rtl/colision_multi.sv
// Multi-display collision checker: lives, post-hit invulnerability, bonus pulses
// and sticky win/lose code. Optional hit/bonus log outputs under COLISION_REGISTRO_EN.
module colision_multi
  import colision_pkg::*;
#(
  parameter int N_DISP      = 3,
  parameter int HERO_POS    = 0,
  parameter int MAX_VIDAS   = 3,
  parameter int VW          = 2,
  parameter int INV_CICLOS  = 4,
  parameter int MUNDO_FINAL = 3
) (
  input  logic                clk_obstaculos,
  input  logic                rst,
  input  logic [2:0]          presente,
  input  logic [1:0]          mundo,
  input  logic [7*N_DISP-1:0] display_obs,
  input  logic [6:0]          heroe,
  output logic [1:0]          W_or_L,
  output logic                bono_tomado,
  output logic [VW-1:0]       vidas,
  output logic                invulnerable,
  output logic                golpe
`ifdef COLISION_REGISTRO_EN
  ,
  output logic [6:0]          ultimo_choque,
  output logic [7:0]          total_bonos
`endif
);

  localparam int IW = (INV_CICLOS > 1) ? $clog2(INV_CICLOS) : 1;
  localparam logic [VW-1:0] VIDAS_MAX = VW'(MAX_VIDAS);
  localparam logic [1:0]    MUNDO_F   = 2'(MUNDO_FINAL);
  localparam logic [IW-1:0] INV_CARGA = IW'(INV_CICLOS - 1);

  logic [6:0] obs;
  logic       choque, es_bono, bono_flanco;
  logic       unused_obs;

  estado_t       state_q, state_d;
  logic [VW-1:0] vidas_q, vidas_d, vidas_mas_uno;
  logic [1:0]    w_or_l_q, w_or_l_d;
  logic [IW-1:0] inv_cnt_q, inv_cnt_d;
  logic          invulnerable_q, invulnerable_d;
  logic          golpe_q, golpe_d;
  logic          bono_tomado_q, bono_tomado_d;
  logic          bono_prev_q, bono_prev_d;

  assign obs        = display_obs[7*HERO_POS +: 7];
  assign unused_obs = ^display_obs;

  detector_display u_detector (
    .obs     (obs),
    .heroe   (heroe),
    .choque  (choque),
    .es_bono (es_bono)
  );

  assign bono_flanco   = es_bono & ~bono_prev_q;
  assign vidas_mas_uno = (vidas_q < VIDAS_MAX) ? vidas_q + VW'(1) : VIDAS_MAX;

  always_comb begin
    state_d        = state_q;
    vidas_d        = vidas_q;
    w_or_l_d       = w_or_l_q;
    inv_cnt_d      = inv_cnt_q;
    invulnerable_d = invulnerable_q;
    golpe_d        = 1'b0;
    bono_tomado_d  = 1'b0;
    bono_prev_d    = es_bono;

    if (presente == P_PA) begin
      bono_prev_d = bono_prev_q;
    end else if (presente != P_GAME && presente != P_WL) begin
      // Leaving the game screens from any state aborts back to idle
      state_d        = INACTIVO;
      vidas_d        = VIDAS_MAX;
      w_or_l_d       = WL_NADA;
      inv_cnt_d      = '0;
      invulnerable_d = 1'b0;
    end else begin
      case (state_q)
        INACTIVO: begin
          vidas_d  = VIDAS_MAX;
          w_or_l_d = WL_NADA;
          if (presente == P_GAME) state_d = JUEGO;
        end
        JUEGO: begin
          bono_tomado_d = bono_flanco;
          if (mundo == MUNDO_F) begin
            state_d  = GANO;
            w_or_l_d = WL_GANA;
          end else if (choque && vidas_q == VW'(1)) begin
            vidas_d  = '0;
            golpe_d  = 1'b1;
            state_d  = PERDIO;
            w_or_l_d = WL_PIERDE;
          end else if (choque) begin
            vidas_d        = vidas_q - VW'(1);
            golpe_d        = 1'b1;
            state_d        = GOLPE;
            inv_cnt_d      = INV_CARGA;
            invulnerable_d = 1'b1;
          end else if (bono_flanco) begin
            vidas_d = vidas_mas_uno;
          end
        end
        GOLPE: begin
          bono_tomado_d = bono_flanco;
          if (mundo == MUNDO_F) begin
            state_d        = GANO;
            w_or_l_d       = WL_GANA;
            invulnerable_d = 1'b0;
          end else begin
            if (bono_flanco) vidas_d = vidas_mas_uno;
            if (inv_cnt_q == '0) begin
              state_d        = JUEGO;
              invulnerable_d = 1'b0;
            end else begin
              inv_cnt_d = inv_cnt_q - IW'(1);
            end
          end
        end
        GANO, PERDIO: begin
          state_d = state_q;
        end
        default: begin
          state_d = INACTIVO;
        end
      endcase
    end
  end

  always_ff @(posedge clk_obstaculos) begin
    if (rst) begin
      state_q        <= INACTIVO;
      vidas_q        <= VIDAS_MAX;
      w_or_l_q       <= WL_NADA;
      inv_cnt_q      <= '0;
      invulnerable_q <= 1'b0;
      golpe_q        <= 1'b0;
      bono_tomado_q  <= 1'b0;
      bono_prev_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      vidas_q        <= vidas_d;
      w_or_l_q       <= w_or_l_d;
      inv_cnt_q      <= inv_cnt_d;
      invulnerable_q <= invulnerable_d;
      golpe_q        <= golpe_d;
      bono_tomado_q  <= bono_tomado_d;
      bono_prev_q    <= bono_prev_d;
    end
  end

  assign W_or_L       = w_or_l_q;
  assign bono_tomado  = bono_tomado_q;
  assign vidas        = vidas_q;
  assign invulnerable = invulnerable_q;
  assign golpe        = golpe_q;

`ifdef COLISION_REGISTRO_EN
  logic [6:0] ultimo_choque_q, ultimo_choque_d;
  logic [7:0] total_bonos_q, total_bonos_d;

  // Log of the last counted hit and bonuses taken; both follow the pause freeze
  always_comb begin
    ultimo_choque_d = ultimo_choque_q;
    total_bonos_d   = total_bonos_q;
    if (presente != P_PA) begin
      if (state_d == INACTIVO) begin
        ultimo_choque_d = '0;
        total_bonos_d   = '0;
      end else begin
        if (golpe_d) ultimo_choque_d = obs & heroe;
        if (bono_tomado_d && total_bonos_q != 8'hFF) total_bonos_d = total_bonos_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_obstaculos) begin
    if (rst) begin
      ultimo_choque_q <= '0;
      total_bonos_q   <= '0;
    end else begin
      ultimo_choque_q <= ultimo_choque_d;
      total_bonos_q   <= total_bonos_d;
    end
  end

  assign ultimo_choque = ultimo_choque_q;
  assign total_bonos   = total_bonos_q;
`endif

endmodule

// File: tb/tb_colision_multi.sv
// Self-checking bench for colision_multi: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural model of the game rules.
module tb_colision_multi;

  localparam int N_DISP      = 3;
  localparam int HERO_POS    = 0;
  localparam int MAX_VIDAS   = 3;
  localparam int VW          = 2;
  localparam int INV_CICLOS  = 4;
  localparam int MUNDO_FINAL = 3;

  localparam logic [2:0] OFF  = 3'd0;
  localparam logic [2:0] GAME = 3'd3;
  localparam logic [2:0] WL   = 3'd4;
  localparam logic [2:0] PA   = 3'd5;

  logic                clk = 1'b0;
  logic                rst;
  logic [2:0]          presente;
  logic [1:0]          mundo;
  logic [7*N_DISP-1:0] display_obs;
  logic [6:0]          heroe;
  logic [1:0]          W_or_L;
  logic                bono_tomado;
  logic [VW-1:0]       vidas;
  logic                invulnerable;
  logic                golpe;
`ifdef COLISION_REGISTRO_EN
  logic [6:0]          ultimo_choque;
  logic [7:0]          total_bonos;
`endif

  int checks = 0;
  int passed = 0;

  // Behavioural model: plain game-rule bookkeeping
  bit m_active;
  int m_result;
  int m_vidas;
  int m_inv_left;
  bit m_prev_bono;
  bit m_golpe;
  bit m_bono;

  colision_multi #(
    .N_DISP(N_DISP), .HERO_POS(HERO_POS), .MAX_VIDAS(MAX_VIDAS), .VW(VW),
    .INV_CICLOS(INV_CICLOS), .MUNDO_FINAL(MUNDO_FINAL)
  ) dut (
    .clk_obstaculos(clk),
    .rst(rst),
    .presente(presente),
    .mundo(mundo),
    .display_obs(display_obs),
    .heroe(heroe),
    .W_or_L(W_or_L),
    .bono_tomado(bono_tomado),
    .vidas(vidas),
    .invulnerable(invulnerable),
    .golpe(golpe)
`ifdef COLISION_REGISTRO_EN
    ,
    .ultimo_choque(ultimo_choque),
    .total_bonos(total_bonos)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_wl();
    if (m_result == 1) return 2'b10;
    if (m_result == 2) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_inv();
    return (m_active && m_result == 0 && m_inv_left > 0);
  endfunction

  task automatic drive(input logic [2:0] p, input logic [1:0] m, input logic [6:0] o, input logic [6:0] h);
    presente = p;
    mundo    = m;
    heroe    = h;
    display_obs = (7*N_DISP)'($urandom);
    display_obs[7*HERO_POS +: 7] = o;
  endtask

  // One clock: model consumes the inputs seen at the edge, then outputs settle
  task automatic step();
    logic [6:0] o;
    bit bonus_now, bonus_edge, hit, playing;
    o = display_obs[7*HERO_POS +: 7];
    bonus_now  = (o == 7'h7F);
    bonus_edge = bonus_now && !m_prev_bono;
    hit        = ((o & heroe) != 0) && !bonus_now;
    playing    = (presente == GAME || presente == WL);
    @(posedge clk);
    if (rst) begin
      m_active = 0; m_result = 0; m_vidas = MAX_VIDAS; m_inv_left = 0;
      m_prev_bono = 0; m_golpe = 0; m_bono = 0;
    end else if (presente == PA) begin
      m_golpe = 0; m_bono = 0;
    end else begin
      m_prev_bono = bonus_now;
      m_golpe = 0; m_bono = 0;
      if (!playing) begin
        m_active = 0; m_result = 0; m_vidas = MAX_VIDAS; m_inv_left = 0;
      end else if (!m_active) begin
        if (presente == GAME) m_active = 1;
      end else if (m_result == 0) begin
        m_bono = bonus_edge;
        if (mundo == 2'(MUNDO_FINAL)) begin
          m_result = 1; m_inv_left = 0;
        end else if (m_inv_left > 0) begin
          m_inv_left--;
          if (bonus_edge && m_vidas < MAX_VIDAS) m_vidas++;
        end else if (hit) begin
          m_golpe = 1;
          m_vidas--;
          if (m_vidas == 0) m_result = 2;
          else m_inv_left = INV_CICLOS;
        end else if (bonus_edge && m_vidas < MAX_VIDAS) begin
          m_vidas++;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(OFF, 2'd0, 7'h00, 7'h00);
    step(); step();
    checks++; if (vidas !== 2'd3) $display("[TB] FAIL reset_vidas got=%0d exp=3", vidas); else passed++;
    checks++; if (W_or_L !== 2'b00 || golpe !== 1'b0 || bono_tomado !== 1'b0 || invulnerable !== 1'b0)
      $display("[TB] FAIL reset_outs got wl=%b g=%b b=%b i=%b exp all 0", W_or_L, golpe, bono_tomado, invulnerable);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_idle_game();
    int golpes = 0;
    for (int i = 0; i < 10; i++) begin
      drive(GAME, 2'd0, 7'h02, 7'h01);
      step();
      golpes += int'(golpe);
    end
    checks++; if (golpes != 0) $display("[TB] FAIL idle_golpe got=%0d exp=0", golpes); else passed++;
    checks++; if (vidas !== 2'd3 || W_or_L !== 2'b00)
      $display("[TB] FAIL idle_state got vidas=%0d wl=%b exp vidas=3 wl=00", vidas, W_or_L);
    else passed++;
  endtask

  task automatic test_hit_window();
    int golpes = 0, inv_high = 0;
    for (int i = 0; i < 5; i++) begin
      drive(GAME, 2'd0, 7'h01, 7'h01);
      step();
      golpes   += int'(golpe);
      inv_high += int'(invulnerable);
      if (i == 0) begin
        checks++; if (golpe !== 1'b1 || vidas !== 2'd2)
          $display("[TB] FAIL hit_first got golpe=%b vidas=%0d exp golpe=1 vidas=2", golpe, vidas);
        else passed++;
      end
    end
    checks++; if (golpes != 1) $display("[TB] FAIL hit_golpes got=%0d exp=1", golpes); else passed++;
    checks++; if (inv_high != INV_CICLOS) $display("[TB] FAIL hit_window got=%0d exp=%0d", inv_high, INV_CICLOS); else passed++;
    checks++; if (vidas !== 2'd2) $display("[TB] FAIL hit_repeat_vidas got=%0d exp=2", vidas); else passed++;
    drive(GAME, 2'd0, 7'h00, 7'h01);
    step();
  endtask

  task automatic test_lose();
    drive(OFF, 2'd0, 7'h00, 7'h01); step();
    drive(GAME, 2'd0, 7'h00, 7'h01); step();
    for (int k = 0; k < 3; k++) begin
      drive(GAME, 2'd0, 7'h41, 7'h01); step();
      checks++; if (vidas !== 2'(2 - k) || golpe !== 1'b1)
        $display("[TB] FAIL lose_hit%0d got vidas=%0d golpe=%b exp vidas=%0d golpe=1", k, vidas, golpe, 2 - k);
      else passed++;
      for (int j = 0; j < 5; j++) begin
        drive(GAME, 2'd0, 7'h00, 7'h01); step();
      end
    end
    drive(GAME, 2'd0, 7'h01, 7'h01); step();
    checks++; if (W_or_L !== 2'b01 || vidas !== 2'd0 || golpe !== 1'b0)
      $display("[TB] FAIL lose_sticky got wl=%b vidas=%0d golpe=%b exp wl=01 vidas=0 golpe=0", W_or_L, vidas, golpe);
    else passed++;
    drive(OFF, 2'd0, 7'h00, 7'h01); step();
    checks++; if (W_or_L !== 2'b00 || vidas !== 2'd3)
      $display("[TB] FAIL lose_abort got wl=%b vidas=%0d exp wl=00 vidas=3", W_or_L, vidas);
    else passed++;
  endtask

  task automatic test_bonus();
    int pulses = 0;
    drive(GAME, 2'd0, 7'h00, 7'h08); step();
    drive(GAME, 2'd0, 7'h08, 7'h08); step();
    for (int j = 0; j < 5; j++) begin
      drive(GAME, 2'd0, 7'h00, 7'h08); step();
    end
    for (int j = 0; j < 5; j++) begin
      drive(GAME, 2'd0, 7'h7F, 7'h08); step();
      pulses += int'(bono_tomado);
    end
    checks++; if (pulses != 1 || vidas !== 2'd3)
      $display("[TB] FAIL bonus_held got pulses=%0d vidas=%0d exp pulses=1 vidas=3", pulses, vidas);
    else passed++;
    pulses = 0;
    drive(GAME, 2'd0, 7'h00, 7'h08); step();
    for (int j = 0; j < 2; j++) begin
      drive(GAME, 2'd0, 7'h7F, 7'h08); step();
      pulses += int'(bono_tomado);
    end
    checks++; if (pulses != 1 || vidas !== 2'd3)
      $display("[TB] FAIL bonus_sat got pulses=%0d vidas=%0d exp pulses=1 vidas=3", pulses, vidas);
    else passed++;
  endtask

  task automatic test_win_priority();
    drive(GAME, 2'(MUNDO_FINAL), 7'h01, 7'h01); step();
    checks++; if (W_or_L !== 2'b10 || golpe !== 1'b0 || vidas !== 2'd3)
      $display("[TB] FAIL win_prio got wl=%b golpe=%b vidas=%0d exp wl=10 golpe=0 vidas=3", W_or_L, golpe, vidas);
    else passed++;
    drive(WL, 2'd0, 7'h01, 7'h01); step();
    checks++; if (W_or_L !== 2'b10) $display("[TB] FAIL win_sticky got=%b exp=10", W_or_L); else passed++;
  endtask

  task automatic test_pause();
    int inv_high = 0;
    drive(OFF, 2'd0, 7'h00, 7'h10); step();
    drive(GAME, 2'd0, 7'h00, 7'h10); step();
    drive(GAME, 2'd0, 7'h10, 7'h10); step();
    drive(GAME, 2'd0, 7'h00, 7'h10); step();
    for (int j = 0; j < 6; j++) begin
      drive(PA, 2'd0, 7'h10, 7'h10); step();
      inv_high += int'(invulnerable && !golpe);
    end
    checks++; if (inv_high != 6 || vidas !== 2'd2)
      $display("[TB] FAIL pause_freeze got inv=%0d vidas=%0d exp inv=6 vidas=2", inv_high, vidas);
    else passed++;
    for (int j = 0; j < 3; j++) begin
      drive(GAME, 2'd0, 7'h00, 7'h10); step();
      checks++; if (invulnerable !== (j < 2))
        $display("[TB] FAIL pause_resume%0d got=%b exp=%b", j, invulnerable, (j < 2));
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [6:0] h, o;
    logic [2:0] p;
    int r;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      r = $urandom_range(0, 99);
      p = (r < 80) ? GAME : (r < 87) ? PA : (r < 93) ? WL : 3'($urandom_range(0, 2));
      h = 7'($urandom);
      case ($urandom_range(0, 3))
        0: o = 7'h7F;
        1: o = h;
        2: o = ~h;
        default: o = 7'($urandom);
      endcase
      drive(p, ($urandom_range(0, 19) == 0) ? 2'(MUNDO_FINAL) : 2'($urandom_range(0, 2)), o, h);
      step();
      checks++; if (vidas !== VW'(m_vidas)) $display("[TB] FAIL rnd_vidas c=%0d got=%0d exp=%0d", c, vidas, m_vidas); else passed++;
      checks++; if (W_or_L !== exp_wl()) $display("[TB] FAIL rnd_wl c=%0d got=%b exp=%b", c, W_or_L, exp_wl()); else passed++;
      checks++; if (golpe !== m_golpe) $display("[TB] FAIL rnd_golpe c=%0d got=%b exp=%b", c, golpe, m_golpe); else passed++;
      checks++; if (bono_tomado !== m_bono) $display("[TB] FAIL rnd_bono c=%0d got=%b exp=%b", c, bono_tomado, m_bono); else passed++;
      checks++; if (invulnerable !== exp_inv()) $display("[TB] FAIL rnd_inv c=%0d got=%b exp=%b", c, invulnerable, exp_inv()); else passed++;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_game();
    test_hit_window();
    test_lose();
    test_bonus();
    test_win_priority();
    test_pause();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
